// File: rtl/conv_layer_sched_if.sv
// Handshake and configuration bundle between the layer scheduler and its host.
// The host (master) issues start/abort and relays the conv controller's finish;
// the scheduler (slave) drives control strobes, layer config and status.
interface conv_layer_sched_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              abort;
  logic              finish;
  logic              en_ctrl;
  logic              ctrl_reset;
  logic [1:0]        layer_idx;
  logic              src_sel;
  logic              rd_buf;
  logic              wr_buf;
  logic [ADDR_W-1:0] wt_base;
  logic [ADDR_W-1:0] bias_base;
  logic [5:0]        in_dim;
  logic [5:0]        in_ch;
  logic [5:0]        out_ch;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       run_cycles;

  modport master (
    output start, abort, finish,
    input  en_ctrl, ctrl_reset, layer_idx, src_sel, rd_buf, wr_buf,
    input  wt_base, bias_base, in_dim, in_ch, out_ch,
    input  busy, done, error, run_cycles
  );

  modport slave (
    input  start, abort, finish,
    output en_ctrl, ctrl_reset, layer_idx, src_sel, rd_buf, wr_buf,
    output wt_base, bias_base, in_dim, in_ch, out_ch,
    output busy, done, error, run_cycles
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer scheduler for the CNN accelerator: walks the shared conv engine through
// three layers per run (restart pulse, enable until finish, drain the last RAM
// write), ping-ponging feature buffers, with a per-layer watchdog and a
// saturating run-length counter.
module conv_layer_sched #(
  parameter int          NUM_LAYERS = 3,
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] TIMEOUT    = 24'd2_000_000,
  parameter int          DRAIN_CYC  = 2
) (
  input logic               clk,
  input logic               reset,
  conv_layer_sched_if.slave io_sched
);

  localparam int DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_cyc;
  logic [31:0]       r_run_cycles;
  logic [23:0]       r_wd;
  logic [DR_W-1:0]   r_dr;
  logic [1:0]        r_layer;
  logic              w_last;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_last = (r_layer == 2'(NUM_LAYERS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_sched.start) w_next = S_CLR;
      S_CLR:   w_next = S_RUN;
      S_RUN: begin
        if (io_sched.finish)              w_next = S_DRAIN;
        else if (r_wd == TIMEOUT - 24'd1) w_next = S_ERR;
      end
      S_DRAIN: if (r_dr == DR_W'(DRAIN_CYC - 1)) w_next = w_last ? S_DONE : S_CLR;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (io_sched.abort) w_next = S_IDLE;
  end

  // Run/watchdog/drain counters, layer index and the latched run length.
  // run_cycles includes the cycle in which the run leaves for IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc        <= '0;
      r_run_cycles <= '0;
      r_wd         <= '0;
      r_dr         <= '0;
      r_layer      <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_next == S_CLR) r_cyc <= '0;
      end else begin
        r_cyc <= sat_inc(r_cyc);
      end

      if (r_state != S_IDLE && w_next == S_IDLE) r_run_cycles <= sat_inc(r_cyc);

      if (r_state == S_CLR)      r_wd <= '0;
      else if (r_state == S_RUN) r_wd <= r_wd + 24'd1;

      if (r_state == S_RUN)        r_dr <= '0;
      else if (r_state == S_DRAIN) r_dr <= r_dr + DR_W'(1);

      if (w_next == S_IDLE)                           r_layer <= '0;
      else if (r_state == S_DRAIN && w_next == S_CLR) r_layer <= r_layer + 2'd1;
    end
  end

  // Control strobes and status decoded from the current state.
  always_comb begin
    io_sched.en_ctrl    = (r_state == S_RUN);
    io_sched.ctrl_reset = (r_state == S_CLR);
    io_sched.busy       = (r_state == S_CLR) || (r_state == S_RUN) || (r_state == S_DRAIN);
    io_sched.done       = (r_state == S_DONE);
    io_sched.error      = (r_state == S_ERR);
    io_sched.layer_idx  = r_layer;
    io_sched.run_cycles = r_run_cycles;
  end

  // Fixed layer table; L0 reads the image RAM, later layers ping-pong A/B.
  always_comb begin
    io_sched.in_dim    = 6'd32;
    io_sched.in_ch     = 6'd3;
    io_sched.out_ch    = 6'd32;
    io_sched.wt_base   = '0;
    io_sched.bias_base = '0;
    io_sched.src_sel   = 1'b0;
    io_sched.rd_buf    = 1'b0;
    io_sched.wr_buf    = 1'b0;
    case (r_layer)
      2'd1: begin
        io_sched.in_dim    = 6'd16;
        io_sched.in_ch     = 6'd32;
        io_sched.out_ch    = 6'd16;
        io_sched.wt_base   = ADDR_W'(2400);
        io_sched.bias_base = ADDR_W'(32);
        io_sched.src_sel   = 1'b1;
        io_sched.rd_buf    = 1'b0;
        io_sched.wr_buf    = 1'b1;
      end
      2'd2: begin
        io_sched.in_dim    = 6'd8;
        io_sched.in_ch     = 6'd16;
        io_sched.out_ch    = 6'd32;
        io_sched.wt_base   = ADDR_W'(15200);
        io_sched.bias_base = ADDR_W'(48);
        io_sched.src_sel   = 1'b1;
        io_sched.rd_buf    = 1'b1;
        io_sched.wr_buf    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: each scenario is written as an expected timeline
// of phases (I=idle, C=clear, R=run, D=drain, F=done, E=error) together with
// the inputs driven in each phase, then replayed cycle by cycle while every
// output is compared with what that phase and layer should show.
module tb_conv_layer_sched;
  localparam int TO  = 120;
  localparam int DRN = 2;

  localparam int T_DIM [3] = '{32, 16, 8};
  localparam int T_IC  [3] = '{3, 32, 16};
  localparam int T_OC  [3] = '{32, 16, 32};
  localparam int T_WT  [3] = '{0, 2400, 15200};
  localparam int T_BI  [3] = '{0, 32, 48};
  localparam int T_SRC [3] = '{0, 1, 1};
  localparam int T_RD  [3] = '{0, 0, 1};
  localparam int T_WR  [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_layer_sched_if #(.ADDR_W(16)) sif();

  conv_layer_sched #(
    .NUM_LAYERS(3), .ADDR_W(16), .TIMEOUT(24'(TO)), .DRAIN_CYC(DRN)
  ) dut (
    .clk(clk), .reset(reset), .io_sched(sif)
  );

  typedef struct {
    byte ph;
    int  ly;
    bit  st, ab, fi, rs;
    int  rc;
  } rec_t;

  rec_t q[$];
  int   n_chk = 0, n_err = 0;
  int   n_clr = 0, n_done = 0;
  byte  prev_ph = "I";
  bit   prev_rs = 1'b0;
  int   m_cnt = 0, m_rc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Append one phase; run_cycles shown in it is the count of non-idle
  // cycles of the run that most recently returned to idle (0 after reset).
  task automatic add(input byte ph, input int ly, input bit st, input bit ab,
                     input bit fi, input bit rs);
    rec_t r;
    if (prev_rs) begin
      m_rc  = 0;
      m_cnt = 0;
    end else if (ph == "I" && prev_ph != "I") begin
      m_rc = m_cnt;
    end
    if (ph == "C" && prev_ph == "I") m_cnt = 0;
    if (ph != "I") m_cnt++;
    r.ph = ph; r.ly = ly; r.st = st; r.ab = ab; r.fi = fi; r.rs = rs; r.rc = m_rc;
    q.push_back(r);
    prev_ph = ph;
    prev_rs = rs;
  endtask

  task automatic layer(input int i, input int lat, input bit noise, input bit held);
    add("C", i, noise ? rb() : 1'b0, 1'b0, held ? 1'b1 : (noise ? rb() : 1'b0), 1'b0);
    for (int j = 1; j <= lat; j++)
      add("R", i, noise ? rb() : 1'b0, 1'b0, j == lat, 1'b0);
    for (int d = 0; d < DRN; d++)
      add("D", i, noise ? rb() : 1'b0, 1'b0, held ? 1'b1 : (noise ? rb() : 1'b0), 1'b0);
  endtask

  task automatic check_rec(input rec_t r, input int k);
    logic [4:0]  e_ctl;
    logic [52:0] e_cfg, o_cfg;
    int          ly;
    ly    = (r.ph == "I") ? 0 : r.ly;
    e_ctl = {r.ph == "R", r.ph == "C", (r.ph == "C") || (r.ph == "R") || (r.ph == "D"),
             r.ph == "F", r.ph == "E"};
    e_cfg = {T_SRC[ly] != 0, T_RD[ly] != 0, T_WR[ly] != 0, 16'(T_WT[ly]), 16'(T_BI[ly]),
             6'(T_DIM[ly]), 6'(T_IC[ly]), 6'(T_OC[ly])};
    o_cfg = {sif.src_sel, (T_SRC[ly] != 0) ? sif.rd_buf : 1'b0, sif.wr_buf, sif.wt_base,
             sif.bias_base, sif.in_dim, sif.in_ch, sif.out_ch};
    chk($sformatf("ctl[%c]@%0d", r.ph, k),
        64'({sif.en_ctrl, sif.ctrl_reset, sif.busy, sif.done, sif.error}), 64'(e_ctl));
    chk($sformatf("layer@%0d", k), 64'(sif.layer_idx), 64'(ly));
    chk($sformatf("cfg@%0d", k), 64'(o_cfg), 64'(e_cfg));
    chk($sformatf("run_cycles@%0d", k), 64'(sif.run_cycles), 64'(r.rc));
    if (sif.ctrl_reset === 1'b1) n_clr++;
    if (sif.done === 1'b1) n_done++;
  endtask

  task automatic play();
    for (int k = 0; k + 1 < q.size(); k++) begin
      sif.start  = q[k].st;
      sif.abort  = q[k].ab;
      sif.finish = q[k].fi;
      reset      = q[k].rs;
      @(posedge clk);
      #1;
      check_rec(q[k + 1], k);
    end
    sif.start = 1'b0; sif.abort = 1'b0; sif.finish = 1'b0; reset = 1'b0;
  endtask

  task automatic full_run(input int l0, input int l1, input int l2, input bit noise,
                          input bit held);
    q.delete();
    add("I", 0, 1'b1, 1'b0, held, 1'b0);
    layer(0, l0, noise, held);
    layer(1, l1, noise, held);
    layer(2, l2, noise, held);
    add("F", 2, noise ? rb() : 1'b0, 1'b0, held, 1'b0);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    sif.start = 1'b0; sif.abort = 1'b0; sif.finish = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({sif.en_ctrl, sif.ctrl_reset, sif.busy, sif.done, sif.error}), 64'd0);
    chk("rst_layer", 64'(sif.layer_idx), 64'd0);
    chk("rst_run_cycles", 64'(sif.run_cycles), 64'd0);
    chk("rst_wt_base", 64'(sif.wt_base), 64'd0);
    chk("rst_in_ch", 64'(sif.in_ch), 64'd3);
    reset = 1'b0;

    // Nominal run, 100 RUN cycles per layer.
    n_clr = 0; n_done = 0;
    full_run(100, 100, 100, 1'b0, 1'b0);
    chk("full_clr_pulses", 64'(n_clr), 64'd3);
    chk("full_done_pulses", 64'(n_done), 64'd1);
    chk("full_run_cycles", 64'(sif.run_cycles), 64'd310);

    // Random latencies with stray start/finish outside their sampling states.
    for (int r = 0; r < 4; r++)
      full_run($urandom_range(1, 100), $urandom_range(1, 100), $urandom_range(1, 100),
               1'b1, 1'b0);

    // finish held high throughout: one advance per RUN entry.
    n_clr = 0; n_done = 0;
    full_run(1, 1, 1, 1'b0, 1'b1);
    chk("held_clr_pulses", 64'(n_clr), 64'd3);
    chk("held_done_pulses", 64'(n_done), 64'd1);
    chk("held_run_cycles", 64'(sif.run_cycles), 64'(3 * (1 + 1 + DRN) + 1));

    // Watchdog trips in L1; start ignored in ERR; abort clears.
    q.delete();
    add("I", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    layer(0, $urandom_range(1, 100), 1'b1, 1'b0);
    add("C", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < TO; j++) add("R", 1, rb(), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) add("E", 1, 1'b1, 1'b0, rb(), 1'b0);
    add("E", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play();

    // Abort during RUN of L2 (finish possibly coincident): no done.
    n_done = 0;
    q.delete();
    add("I", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    layer(0, $urandom_range(1, 60), 1'b0, 1'b0);
    layer(1, $urandom_range(1, 60), 1'b0, 1'b0);
    add("C", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    k = $urandom_range(1, 50);
    for (int j = 1; j < k; j++) add("R", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    add("R", 2, 1'b0, 1'b1, rb(), 1'b0);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play();
    chk("abort_done_pulses", 64'(n_done), 64'd0);

    // start and abort together in IDLE: stays idle.
    q.delete();
    add("I", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play();

    // Reset during DRAIN of L0, then a normal run.
    n_done = 0;
    q.delete();
    add("I", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    add("C", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    k = $urandom_range(1, 40);
    for (int j = 1; j <= k; j++) add("R", 0, 1'b0, 1'b0, j == k, 1'b0);
    add("D", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("I", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play();
    chk("reset_done_pulses", 64'(n_done), 64'd0);
    full_run($urandom_range(1, 50), $urandom_range(1, 50), $urandom_range(1, 50),
             1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Top-level layer scheduler for the CNN accelerator. Steps the shared convolution engine (conv controller + convolve datapath + weight/bias/feature RAMs) through three conv layers in order, one per run. For each layer it presents that layer's configuration, pulses a clean restart into the conv controller and enables it. It then waits for the controller's `finish`, drains the final write and advances. Feature maps ping-pong between two buffers; a watchdog traps a hung layer.

## Interface
Parameters:
- `NUM_LAYERS`, 3: layers per run; layer table fixed for indices 0..2.
- `ADDR_W`, 16: width of all base-address outputs.
- `TIMEOUT`, 24'd2_000_000: max RUN cycles per layer before error.
- `DRAIN_CYC`, 2: idle cycles after `finish` before the next layer, covering the RAM write.

Ports:
- `clk`  in  1: system clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a run; sampled only in IDLE.
- `abort`  in  1: return to IDLE from any state next cycle; clears error.
- `finish`  in  1: layer-complete from conv controller; sampled only in RUN.
- `en_ctrl`  out  1: enable to conv controller; high only in RUN.
- `ctrl_reset`  out  1: restart pulse to conv controller; high only in CLR.
- `layer_idx`  out  2: current layer.
- `src_sel`  out  1: 0 = image RAM, 1 = feature buffer selected by `rd_buf`.
- `rd_buf`, `wr_buf`  out  1 each: feature buffer read / written (0 = A, 1 = B).
- `wt_base`, `bias_base`  out  ADDR_W: base addresses in the weight and bias RAMs.
- `in_dim`  out  6: input height/width.
- `in_ch`, `out_ch`  out  6: input and output channel counts.
- `busy`  out  1: high in CLR, RUN, DRAIN.
- `done`  out  1: one-cycle pulse at run completion.
- `error`  out  1: sticky watchdog flag.
- `run_cycles`  out  32: cycle count of the last completed or aborted run.

## Operation
- Layer table (combinational on `layer_idx`):
  - L0: dim 32, in_ch 3, out_ch 32, wt_base 0, bias_base 0, src_sel 0, wr_buf 0.
  - L1: dim 16, in_ch 32, out_ch 16, wt_base 2400, bias_base 32, src_sel 1, rd_buf 0, wr_buf 1.
  - L2: dim 8, in_ch 16, out_ch 32, wt_base 15200, bias_base 48, src_sel 1, rd_buf 1, wr_buf 0.
- States: IDLE, CLR, RUN, DRAIN, DONE, ERR.
  - IDLE: `layer_idx`=0. On `start`, go to CLR and clear the cycle counter.
  - CLR: one cycle; `ctrl_reset`=1. Go to RUN.
  - RUN: `en_ctrl`=1; the watchdog counts RUN cycles. On `finish`=1, go to DRAIN. If the watchdog reaches TIMEOUT with no `finish`, go to ERR.
  - DRAIN: `en_ctrl`=0 for DRAIN_CYC cycles. Then, if `layer_idx`==NUM_LAYERS-1, go to DONE; otherwise increment `layer_idx` and go to CLR.
  - DONE: one cycle; `done`=1; latch `run_cycles`. Go to IDLE.
  - ERR: `error`=1 and `layer_idx` holds the failing layer. Exit only via `abort` or `reset`, both going to IDLE.
- The watchdog clears on entry to each CLR. The run cycle counter increments in every non-IDLE state and saturates at 2^32-1.
- Config outputs are stable from CLR through DRAIN of a layer; they change only on the DRAIN→CLR edge.
- `abort` has priority over every other transition. On abort, `run_cycles` latches the count, `error` clears, and outputs take IDLE values the next cycle.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins, so the block stays IDLE.

## Timing
- Reset values: state IDLE, `layer_idx`=0, `en_ctrl`=0, `ctrl_reset`=0, `busy`=0, `done`=0, `error`=0, `run_cycles`=0. Config outputs show L0.
- `start` at cycle t: CLR at t+1 (`ctrl_reset`, `busy`=1), RUN at t+2 (`en_ctrl`=1).
- `finish` seen at cycle f: `en_ctrl`=0 at f+1. The next layer's CLR is at f+1+DRAIN_CYC.
- Last layer: DONE, and therefore `done`, at f+1+DRAIN_CYC. IDLE the cycle after.
- `finish` outside RUN (CLR, DRAIN, IDLE) has no effect.
- Reset mid-run returns to reset values the next cycle; no `done` is produced.

## Test plan
- Full run, `finish` modelled 100 RUN cycles after each enable, DRAIN_CYC=2: `ctrl_reset` pulses 3 times; `layer_idx` steps 0,1,2; wt_base 0/2400/15200; single `done`; `run_cycles` = 3×(1+100+2)+1 = 310.
- TIMEOUT=50, `finish` never asserted in L1: ERR after 50 RUN cycles with `layer_idx`=1 and `error`=1. `start` is then ignored; `abort` clears to IDLE.
- `abort` in RUN of L2: `en_ctrl`=0 next cycle, IDLE, no `done`, `layer_idx`=0.
- `start` pulsed during RUN and DRAIN: no effect on sequence or cycle count.
- `finish` held high from CLR onward: one layer advance per RUN entry; CLR never advances.
- `reset` asserted in DRAIN of L0: all outputs at reset values the next cycle; a new `start` runs L0 normally.
